// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 1250;

  // Width of the occupancy count exported by the transmit buffer (holds 0..4).
  localparam int COUNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // $clog2 that never returns zero, so one-entry or one-cycle configurations
  // still get a legal one-bit register.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO feeding the transmitter. The head entry is readable
// combinationally so the FSM can pop it in the same cycle it sees a non-empty
// count. Occupancy-based full flag is taken from the registered count only.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head,
  output logic [COUNT_W-1:0]   count,
  output logic                 full
);

  localparam int                 PTR_W    = min1_clog2(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 push_ok;
  logic                 pop_ok;

  // A push into a full buffer is dropped even if a pop happens the same cycle.
  assign full    = (count_reg == DEPTH_C);
  assign push_ok = push && !full && !srst;
  assign pop_ok  = pop && (count_reg != '0);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count as is.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter. Bytes are queued in uart_tx_fifo and sent
// LSB first; a byte waiting at the end of a stop bit starts the next frame
// with no idle gap. The serial line is registered, so it trails the state
// register by one cycle throughout the frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 iCE_CLK,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 RS232_Tx_TTL,
  output logic                 tx_busy,
  output logic [COUNT_W-1:0]   fifo_count
);

  localparam int                CLK_W    = min1_clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0]  LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);
  localparam int                BIT_W    = min1_clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t            state_reg;
  logic [CLK_W-1:0]     clk_cnt_reg;
  logic [BIT_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 line_reg;

  logic [DATA_BITS-1:0] fifo_head;
  logic [COUNT_W-1:0]   fifo_count_w;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic                 bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iCE_CLK),
    .srst      (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count_w),
    .full      (fifo_full)
  );

  assign bit_end = (clk_cnt_reg == LAST_CLK);

  // Pop from IDLE as soon as data is present, or in the final stop-bit cycle
  // so the next start bit follows immediately.
  assign fifo_pop = (fifo_count_w != '0) &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

  assign tx_ready     = !fifo_full;
  assign fifo_count   = fifo_count_w;
  assign tx_busy      = (state_reg != IDLE);
  assign RS232_Tx_TTL = line_reg;

  // Frame sequencer: state, bit-period counter, bit index, shifter and line.
  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      line_reg    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          line_reg    <= 1'b1;
          clk_cnt_reg <= '0;
          if (fifo_pop) begin
            shift_reg   <= fifo_head;
            bit_idx_reg <= '0;
            state_reg   <= START;
          end
        end

        START: begin
          line_reg <= 1'b0;
          if (bit_end) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          line_reg <= shift_reg[0];
          if (bit_end) begin
            clk_cnt_reg <= '0;
            shift_reg   <= shift_reg >> 1;
            if (bit_idx_reg == LAST_BIT) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        STOP: begin
          line_reg <= 1'b1;
          if (bit_end) begin
            clk_cnt_reg <= '0;
            if (fifo_pop) begin
              shift_reg   <= fifo_head;
              bit_idx_reg <= '0;
              state_reg   <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          clk_cnt_reg <= '0;
          line_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with four clocks per bit and a four-entry buffer.
// A mid-bit decoder logs every frame seen on the line; the main sequence
// compares the log against the bytes it expects, in order.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       line;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];

  // Decoder log: {stop_bit, start_bit, data_byte}
  logic [9:0] rx_log [256];
  int         rx_n  = 0;
  int         rx_rd = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .iCE_CLK      (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .RS232_Tx_TTL (line),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where the start bit is first visible; checks all
  // 40 line samples and counts cycles with tx_busy high.
  task automatic watch_frame(input logic [7:0] b, output int busy_hi);
    logic [9:0] bits;
    bits    = {1'b1, b, 1'b0};
    busy_hi = 0;
    for (int j = 0; j < 10 * CPB; j++) begin
      check($sformatf("line_%02h_cyc%0d", b, j), 32'(line), 32'(bits[j / CPB]));
      if (tx_busy) busy_hi++;
      @(negedge clk);
    end
    $display("frame 0x%02h watched, busy cycles=%0d", b, busy_hi);
  endtask

  // Compare every decoded frame against the scoreboard, then expect it empty.
  task automatic drain_rx(input string tag);
    logic [7:0] exp_b;
    while (rx_rd < rx_n) begin
      check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
      exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      check({tag, "_rx_byte"},  32'(rx_log[rx_rd][7:0]), 32'(exp_b));
      check({tag, "_rx_start"}, 32'(rx_log[rx_rd][8]), 32'd0);
      check({tag, "_rx_stop"},  32'(rx_log[rx_rd][9]), 32'd1);
      $display("rx frame %0d: 0x%02h expected 0x%02h", rx_rd, rx_log[rx_rd][7:0], exp_b);
      rx_rd++;
    end
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Mid-bit sampling decoder; aborts any frame in progress on reset.
  logic       rx_active = 1'b0;
  logic       rx_prev   = 1'b1;
  logic       rx_start_bit;
  logic [7:0] rx_byte;
  int         rx_cnt = 0;
  int         rx_k;
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      rx_prev   = 1'b1;
    end else begin
      if (!rx_active) begin
        if (rx_prev && !line) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active && (rx_cnt % CPB == CPB / 2)) begin
        rx_k = rx_cnt / CPB;
        if (rx_k == 0) begin
          rx_start_bit = line;
        end else if (rx_k <= 8) begin
          rx_byte[3'(rx_k - 1)] = line;
        end else begin
          rx_log[rx_n[7:0]] = {line, rx_start_bit, rx_byte};
          rx_n++;
          rx_active = 1'b0;
        end
      end
      rx_prev = line;
    end
  end

  int bh;
  int gaps;
  int lows;

  initial begin
    // Reset with a byte offered: must not be accepted.
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line",  32'(line), 32'd1);
    check("rst_busy",  32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_line",  32'(line), 32'd1);

    // Single byte 0x55 into an idle block.
    @(posedge clk); #1;
    tx_data = 8'h55; tx_valid = 1'b1; sb.push_back(8'h55);
    @(posedge clk); #1;                   // edge N: accepted
    tx_valid = 1'b0;
    @(negedge clk);
    check("t55_count_n",  32'(fifo_count), 32'd1);
    check("t55_line_n",   32'(line), 32'd1);
    check("t55_busy_n",   32'(tx_busy), 32'd0);
    @(negedge clk);                       // after N+1: popped
    check("t55_count_n1", 32'(fifo_count), 32'd0);
    check("t55_busy_n1",  32'(tx_busy), 32'd1);
    check("t55_line_n1",  32'(line), 32'd1);
    @(negedge clk);                       // after N+2: start bit
    watch_frame(8'h55, bh);
    check("t55_busy_cycles", 32'(bh), 32'd39);
    check("t55_line_after", 32'(line), 32'd1);
    check("t55_busy_after", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    drain_rx("t55");

    // tx_valid held, A0..A5 offered; buffer fills, A5 waits for a slot.
    for (int i = 0; i < 6; i++) sb.push_back(8'hA0 + 8'(i));
    @(posedge clk); #1;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'hA0 + 8'(i);
      @(negedge clk);
      check($sformatf("tA_ready_pre%0d", i), 32'(tx_ready), 32'd1);
      @(posedge clk); #1;                 // edges N..N+4
    end
    tx_data = 8'hA5;
    @(negedge clk);
    check("tA_count_full", 32'(fifo_count), 32'd4);
    check("tA_ready_full", 32'(tx_ready), 32'd0);
    repeat (36) @(posedge clk);           // edge N+40
    @(negedge clk);
    check("tA_count_n40", 32'(fifo_count), 32'd4);
    check("tA_ready_n40", 32'(tx_ready), 32'd0);
    @(negedge clk);                       // after N+41: pop, push refused
    check("tA_count_n41", 32'(fifo_count), 32'd3);
    check("tA_ready_n41", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;                   // edge N+42: A5 accepted
    tx_valid = 1'b0;
    @(negedge clk);
    check("tA_count_n42", 32'(fifo_count), 32'd4);
    check("tA_ready_n42", 32'(tx_ready), 32'd0);
    gaps = 0;
    for (int k = 43; k <= 240; k++) begin
      @(negedge clk);
      if (!tx_busy) gaps++;
    end
    check("tA_busy_gaps", 32'(gaps), 32'd0);
    @(negedge clk);                       // after N+241
    check("tA_busy_end",  32'(tx_busy), 32'd0);
    check("tA_count_end", 32'(fifo_count), 32'd0);
    check("tA_line_end",  32'(line), 32'd1);
    repeat (3) @(negedge clk);
    drain_rx("tA");

    // 0x00 then 0xFF back to back.
    sb.push_back(8'h00); sb.push_back(8'hFF);
    @(posedge clk); #1;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;                   // edge N
    tx_data = 8'hFF;
    @(posedge clk); #1;                   // edge N+1
    tx_valid = 1'b0;
    @(negedge clk);                       // after N+1
    @(negedge clk);                       // after N+2
    watch_frame(8'h00, bh);
    check("t00_busy_cycles", 32'(bh), 32'd40);
    watch_frame(8'hFF, bh);
    check("tFF_busy_cycles", 32'(bh), 32'd39);
    check("tFF_line_after", 32'(line), 32'd1);
    repeat (3) @(negedge clk);
    drain_rx("t00FF");

    // Fill buffer to four while busy, then offer 0x77 into a full buffer.
    for (int i = 0; i < 5; i++) sb.push_back(8'h11 * 8'(i + 1));
    @(posedge clk); #1;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h11 * 8'(i + 1);
      @(posedge clk); #1;
    end
    tx_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t77_count%0d", i), 32'(fifo_count), 32'd4);
      check($sformatf("t77_ready%0d", i), 32'(tx_ready), 32'd0);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("t77_busy_end",  32'(tx_busy), 32'd0);
    check("t77_count_end", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    drain_rx("t77");

    // Reset during data bit 3 of 0x3C with two bytes queued.
    @(posedge clk); #1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clk); #1;                   // edge N
    tx_data = 8'hAA;
    @(posedge clk); #1;                   // edge N+1
    tx_data = 8'hBB;
    @(posedge clk); #1;                   // edge N+2
    tx_valid = 1'b0;
    @(negedge clk);
    check("t3C_count_queued", 32'(fifo_count), 32'd2);
    repeat (16) @(posedge clk);           // edge N+18
    #1;
    check("t3C_busy_pre", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;                   // edge N+19: reset sampled
    rst = 1'b0;
    @(negedge clk);
    check("t3C_line_rst",  32'(line), 32'd1);
    check("t3C_count_rst", 32'(fifo_count), 32'd0);
    check("t3C_busy_rst",  32'(tx_busy), 32'd0);
    check("t3C_ready_rst", 32'(tx_ready), 32'd1);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!line) lows++;
    end
    check("t3C_no_resume", 32'(lows), 32'd0);
    check("t3C_no_frames", 32'(rx_n - rx_rd), 32'd0);

    sb.push_back(8'h0F);
    @(posedge clk); #1;
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(posedge clk); #1;                   // edge N
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                       // after N+2
    watch_frame(8'h0F, bh);
    check("t0F_busy_cycles", 32'(bh), 32'd39);
    check("t0F_line_after", 32'(line), 32'd1);
    repeat (3) @(negedge clk);
    drain_rx("t0F");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, iCE_CLK cycles per serial bit (12 MHz / 9600 baud).
REQ-002 Parameter FIFO_DEPTH, default 4, number of buffered bytes; power of two.
REQ-003 iCE_CLK  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  byte to transmit.
REQ-006 tx_valid  input  1  tx_data valid this cycle.
REQ-007 tx_ready  output  1  FIFO can accept a byte (count < FIFO_DEPTH).
REQ-008 RS232_Tx_TTL  output  1  serial line, idle high, registered.
REQ-009 tx_busy  output  1  high whenever state is not IDLE.
REQ-010 fifo_count  output  3  bytes currently buffered, 0..FIFO_DEPTH.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-012 A byte SHALL be accepted at a rising edge where tx_valid and tx_ready are both high; otherwise tx_data is ignored.
REQ-013 tx_ready SHALL be a function of the registered fifo_count only; it SHALL be low when fifo_count == FIFO_DEPTH, even if a pop occurs that cycle.
REQ-014 Push while full SHALL not overwrite FIFO contents; fifo_count unchanged.
REQ-015 FIFO SHALL support simultaneous push and pop; fifo_count then unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 States SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: line high; if fifo_count > 0, pop head into 8-bit shift register, reset bit counter, go to START.
REQ-018 START: line low for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-019 DATA: line = shift[0] per bit; after CLKS_PER_BIT cycles shift right, increment index; after index 7 go to STOP.
REQ-020 STOP: line high for CLKS_PER_BIT cycles; in the last STOP cycle, if fifo_count > 0, pop and go directly to START (no idle gap), else go to IDLE.
REQ-021 Latency: byte accepted at edge N with FIFO empty and state IDLE SHALL drive RS232_Tx_TTL low from edge N+2 (pop at edge N+1, registered line update at N+2).
REQ-022 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL restart at 0 on every state entry.
REQ-023 Bytes SHALL be transmitted in acceptance order.

Reset
REQ-024 With rst high at an edge: state IDLE, RS232_Tx_TTL = 1, tx_busy = 0, fifo_count = 0, pointers 0, tx_ready = 1 after that edge.
REQ-025 Reset mid-frame SHALL abort the frame immediately (line high after the reset edge) and discard all buffered bytes.
REQ-026 A byte presented with tx_valid during rst high SHALL NOT be accepted.

Structure
REQ-027 Shared package uart_pkg SHALL hold DATA_BITS = 8, default CLKS_PER_BIT = 1250, and the tx state enum; shared with the receiver.
REQ-028 Buffer SHALL be a sub-module uart_tx_fifo (push/pop/count, same clock and reset); FSM, counters, shifter stay in uart_tx.

Verification (CLKS_PER_BIT = 4)
REQ-029 Single byte 0x55 into idle block -> line 0,1,0,1,0,1,0,1,0,1, each 4 cycles, start at edge N+2; tx_busy high 40 cycles; line high after.
REQ-030 tx_valid held, bytes 0xA0..0xA5 offered one per cycle -> 0xA0..0xA4 accepted on consecutive edges, tx_ready low after 5th, 0xA5 accepted when first pop frees a slot; six frames back-to-back, no idle gap, correct order.
REQ-031 Bytes 0x00 then 0xFF -> data bits all 0 then all 1; stop bit high in both; start bit low in both.
REQ-032 Fill FIFO to 4 with line busy, push 0x77 with tx_valid high -> not accepted, fifo_count stays 4, 0x77 never transmitted.
REQ-033 rst pulsed during DATA bit 3 of 0x3C with 2 bytes buffered -> line high next cycle, fifo_count 0, tx_busy 0; subsequent 0x0F sends a correct frame.
REQ-034 Bench SHALL include a bit-sampling checker that decodes RS232_Tx_TTL at mid-bit and compares against a scoreboard of accepted bytes.
